// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one single-cycle ALU among NREQ requesters with a registered tagged response.
// Optional per-requester grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_func,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  input  logic                 stat_clr,
  output logic [16*NREQ-1:0]   stat_grants
);
  typedef enum logic [4:0] {
    F_NOP, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLL, F_SRL, F_SRA, F_SLT, F_SLTU
  } func_t;
  logic [IDW-1:0] rr_last, gnt_id;
  logic           found, free, hs;
  logic [4:0]     sel_f;
  logic [31:0]    sel_a, sel_b, alu_res;
  logic           alu_err;
  int             idx;
  // Search starts just past the last winner, so a lone requester still wins every free cycle.
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    sel_f = '0;
    sel_a = '0;
    sel_b = '0;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_last) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt_id = IDW'(idx);
        sel_f = req_func[5*idx +: 5];
        sel_a = req_a[32*idx +: 32];
        sel_b = req_b[32*idx +: 32];
      end
    end
  end
  assign free = !rsp_valid || rsp_ready;
  always_comb begin
    req_ready = '0;
    if (found && free && !rst) req_ready[gnt_id] = 1'b1;
  end
  assign hs = |(req_valid & req_ready);
  // Illegal codes yield a clean zero so nothing undefined reaches the consumer.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (func_t'(sel_f))
      F_ADD:   alu_res = sel_a + sel_b;
      F_SUB:   alu_res = sel_a - sel_b;
      F_AND:   alu_res = sel_a & sel_b;
      F_OR:    alu_res = sel_a | sel_b;
      F_XOR:   alu_res = sel_a ^ sel_b;
      F_SLL:   alu_res = sel_a << sel_b[4:0];
      F_SRL:   alu_res = sel_a >> sel_b[4:0];
      F_SRA:   alu_res = $signed(sel_a) >>> sel_b[4:0];
      F_SLT:   alu_res = {31'b0, $signed(sel_a) < $signed(sel_b)};
      F_SLTU:  alu_res = {31'b0, sel_a < sel_b};
      default: alu_err = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      rr_last <= IDW'(NREQ-1);
    end else if (hs) begin
      rsp_valid <= 1'b1;
      rsp_id <= gnt_id;
      rsp_data <= alu_res;
      rsp_err <= alu_err;
      rr_last <= gnt_id;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
`ifdef ALU_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (stat_clr) cnt <= '0;
      else if (hs && gnt_id == IDW'(g) && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign stat_grants[16*g +: 16] = cnt;
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_grants = '0;
`endif
endmodule
